// File: rtl/mnist_pkg.sv
// ============================================================================
// Module   : mnist_pkg
// Purpose  : Shared constants and state encoding for the MNIST MLP front-end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mnist_pkg;

  localparam int unsigned NPIX      = 784;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SCALE     = 65793;
  localparam int unsigned FRAC_BITS = 24;
  localparam int unsigned IDX_W     = $clog2(NPIX);
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pix_to_q824.sv
// ============================================================================
// Module   : pix_to_q824
// Purpose  : Combinational u8 pixel to Q8.24 conversion (pixel * 2^24/255).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pix_to_q824
  import mnist_pkg::*;
(
  input  logic [PIX_W-1:0]  pix_data,
  output logic [DATA_W-1:0] pix_q
);

  localparam logic [DATA_W-1:0] c_scale = DATA_W'(SCALE);

  // 255 * c_scale = 0x00FFFFFF, so the product never reaches the sign bit.
  assign pix_q = {{(DATA_W-PIX_W){1'b0}}, pix_data} * c_scale;

endmodule

`default_nettype wire

// File: rtl/mnist_pixel_loader.sv
// ============================================================================
// Module   : mnist_pixel_loader
// Purpose  : Buffers a 28x28 pixel stream as Q8.24 and launches inference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mnist_pixel_loader
  import mnist_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [PIX_W-1:0]             pix_data,
  input  logic                         pix_last,
  output logic [NPIX-1:0][DATA_W-1:0]  image_pixels,
  output logic                         start,
  input  logic                         accel_done,
  output logic                         frame_err,
  output logic [CNT_W-1:0]             frame_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_err_nxt;
  logic               r_start;
  logic               r_frame_err;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               w_xfer;
  logic               w_at_end;
  logic [DATA_W-1:0]  w_pix_q;

  assign pix_ready = !reset && (r_state == FILL);
  assign w_xfer    = pix_valid && pix_ready;
  assign w_at_end  = (r_idx == IDX_W'(NPIX-1));

  pix_to_q824 u_conv (
    .pix_data (pix_data),
    .pix_q    (w_pix_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_start     <= (r_state == LAUNCH);
      r_frame_err <= w_err_nxt;
      if (r_state == LAUNCH) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = 1'b0;
    case (r_state)
      FILL: begin
        if (w_xfer) begin
          if (w_at_end && pix_last) begin
            w_state_nxt = LAUNCH;
            w_idx_nxt   = '0;
          end else if (w_at_end || pix_last) begin
            // Short or long frame: drop it and resync to the next frame.
            w_err_nxt = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (accel_done) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // One register per pixel; only the addressed word loads on a transfer.
  for (genvar gi = 0; gi < NPIX; gi++) begin : g_buf
    logic [DATA_W-1:0] r_word;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_word <= '0;
      end else if (w_xfer && (r_idx == IDX_W'(gi))) begin
        r_word <= w_pix_q;
      end
    end
    assign image_pixels[gi] = r_word;
  end

  assign start     = r_start;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mnist_pixel_loader.sv
// ============================================================================
// Module   : tb_mnist_pixel_loader
// Purpose  : Directed self-checking bench for mnist_pixel_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mnist_pixel_loader;
  import mnist_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        pix_valid;
  logic                        pix_ready;
  logic [7:0]                  pix_data;
  logic                        pix_last;
  logic [NPIX-1:0][31:0]       image_pixels;
  logic                        start;
  logic                        accel_done;
  logic                        frame_err;
  logic [15:0]                 frame_cnt;

  int n_checks   = 0;
  int n_errors   = 0;
  int start_seen = 0;

  mnist_pixel_loader dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .image_pixels (image_pixels),
    .start        (start),
    .accel_done   (accel_done),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) start_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_q(input int d);
    return 32'(d * 65793);
  endfunction

  function automatic int buf_mism();
    int m = 0;
    for (int i = 0; i < NPIX; i++)
      if (image_pixels[i] !== exp_q(i % 256)) m++;
    return m;
  endfunction

  function automatic int buf_nonzero();
    int m = 0;
    for (int i = 0; i < NPIX; i++)
      if (image_pixels[i] !== 32'd0) m++;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; returns after the pixel has been accepted.
  task automatic send_pixel(input logic [7:0] d, input logic last, input bit stall);
    int   guard = 0;
    logic rdy;
    if (stall) begin
      while ($urandom_range(0, 1) == 0) begin
        pix_valid = 1'b0;
        tick();
      end
    end
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    forever begin
      @(negedge clk);
      rdy = pix_ready;
      tick();
      if (rdy) break;
      guard++;
      if (guard > 100) begin
        check("accept_timeout", 32'(guard), 32'd0);
        break;
      end
    end
  endtask

  task automatic send_frame(input int n, input int last_at, input int off, input bit stall);
    for (int k = 0; k < n; k++)
      send_pixel(8'((k + off) % 256), (k == last_at), stall);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Called in the cycle after the final transfer.
  task automatic expect_launch(input logic [15:0] cnt);
    @(negedge clk);
    check("start_early", 32'(start), 32'd0);
    check("ready_launch", 32'(pix_ready), 32'd0);
    tick();
    @(negedge clk);
    check("start_pulse", 32'(start), 32'd1);
    check("frame_cnt", 32'(frame_cnt), 32'(cnt));
    tick();
    @(negedge clk);
    check("start_once", 32'(start), 32'd0);
    tick();
  endtask

  task automatic release_accel();
    accel_done = 1'b1;
    pix_valid  = 1'b0;
    @(negedge clk);
    check("ready_wait", 32'(pix_ready), 32'd0);
    tick();
    accel_done = 1'b0;
    @(negedge clk);
    check("ready_after_done", 32'(pix_ready), 32'd1);
    tick();
  endtask

  initial begin
    int s0;
    int ready_bad;
    reset      = 1'b1;
    pix_valid  = 1'b0;
    pix_data   = 8'd0;
    pix_last   = 1'b0;
    accel_done = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_buf", 32'(buf_nonzero()), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("ready_post_rst", 32'(pix_ready), 32'd1);
    tick();

    // accel_done in FILL is ignored
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    @(negedge clk);
    check("done_in_fill_ready", 32'(pix_ready), 32'd1);
    check("done_in_fill_start", 32'(start_seen), 32'd0);
    tick();

    // Full frame, no stalls
    send_frame(NPIX, NPIX - 1, 0, 1'b0);
    expect_launch(16'd1);
    check("pix0", image_pixels[0], 32'd0);
    check("pix1", image_pixels[1], 32'd65793);
    check("pix255", image_pixels[255], 32'h00FF_FFFF);
    check("pix783", image_pixels[783], 32'(15 * 65793));
    check("buf_frame1", 32'(buf_mism()), 32'd0);

    // WAIT holds off the stream and freezes the buffer
    s0 = start_seen;
    ready_bad = 0;
    pix_valid = 1'b1;
    pix_data  = 8'hAA;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pix_ready !== 1'b0) ready_bad++;
      tick();
    end
    check("wait_ready", 32'(ready_bad), 32'd0);
    check("wait_buf", 32'(buf_mism()), 32'd0);
    check("wait_no_start", 32'(start_seen), 32'(s0));
    release_accel();

    // Short frame: pix_last on pixel #100, data offset so the next frame must rewrite
    s0 = start_seen;
    send_frame(101, 100, 7, 1'b0);
    @(negedge clk);
    check("short_err", 32'(frame_err), 32'd1);
    check("short_ready", 32'(pix_ready), 32'd1);
    tick();
    @(negedge clk);
    check("short_err_pulse", 32'(frame_err), 32'd0);
    check("short_no_start", 32'(start_seen), 32'(s0));
    check("short_cnt", 32'(frame_cnt), 32'd1);
    tick();

    // Full frame with random stalls
    s0 = start_seen;
    send_frame(NPIX - 1, -1, 0, 1'b1);
    check("stall_no_early", 32'(start_seen), 32'(s0));
    send_pixel(8'((NPIX - 1) % 256), 1'b1, 1'b1);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    expect_launch(16'd2);
    check("buf_frame2", 32'(buf_mism()), 32'd0);
    release_accel();

    // Long frame: no pix_last on pixel #783
    s0 = start_seen;
    send_frame(NPIX, -1, 0, 1'b0);
    @(negedge clk);
    check("long_err", 32'(frame_err), 32'd1);
    tick();
    @(negedge clk);
    check("long_err_pulse", 32'(frame_err), 32'd0);
    check("long_no_start", 32'(start_seen), 32'(s0));
    check("long_cnt", 32'(frame_cnt), 32'd2);
    tick();

    // Reset in the middle of a frame
    s0 = start_seen;
    send_frame(400, -1, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(pix_ready), 32'd0);
    tick();
    @(negedge clk);
    check("midrst_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_buf", 32'(buf_nonzero()), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_post", 32'(pix_ready), 32'd1);
    check("midrst_no_start", 32'(start_seen), 32'(s0));
    tick();
    send_frame(NPIX, NPIX - 1, 0, 1'b0);
    expect_launch(16'd1);
    check("buf_frame3", 32'(buf_mism()), 32'd0);
    release_accel();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
